uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

- Shares one byte-wide UART transmitter between N independent payload sources.
- Wraps each granted burst in a frame: 0x55 SOF, port-ID byte, payload bytes, 0xAA EOF.
- Arbitrates round-robin at frame granularity and paces every byte on the transmitter's tx_busy.
- Sits between the producer blocks and the UART TX, replacing direct streamer-to-UART wiring when more than one source must share the link.

## Interface
- N, default 2: number of requesters, 2..8.
- MAX_LEN, default 64: maximum payload bytes per frame, 1..256. Longer bursts are fragmented.
- clk  in  1: system clock, all logic on rising edge.
- rst_n  in  1: asynchronous, active-low reset.
- req_valid  in  N: per-port payload byte available.
- req_data  in  8N: per-port byte; port i occupies bits [8i+7:8i].
- req_last  in  N: per-port marker; the byte carries the last byte of the burst.
- req_ready  out  N: combinational; a byte of port i transfers when req_valid[i] & req_ready[i].
- tx_busy  in  1: UART busy. It is high from the cycle after tx_start until the byte completes.
- tx_start  out  1: registered one-cycle pulse that launches tx_data.
- tx_data  out  8: registered byte, valid in the cycle tx_start is high.
- grant  out  N: registered one-hot owner of the current frame; all zero when idle.
- frag_pulse  out  1: registered one-cycle pulse when a frame is closed by MAX_LEN rather than req_last.

## Operation
- can_send = !tx_busy & !tx_start. The tx_start term covers the one-cycle gap before tx_busy rises.
- FSM states: IDLE, SOF, ID, DATA, EOF.
- IDLE:
  - If any req_valid is high, grant the first requesting port at or after rr_ptr, scanning upward with wrap.
  - Register grant, clear len, go to SOF.
  - With no requests, stay in IDLE and hold grant at 0.
- SOF: when can_send, tx_start=1 and tx_data=8'h55, go to ID.
- ID: when can_send, tx_start=1 and tx_data=granted index zero-extended to 8 bits, go to DATA.
- DATA:
  - req_ready[g] = can_send & req_valid[g]; all other req_ready bits are 0.
  - On a transfer: tx_start=1, tx_data=req_data[g], len increments.
  - If req_last[g] or len==MAX_LEN-1, go to EOF. On the MAX_LEN condition without req_last, also pulse frag_pulse.
  - If the granted port drops req_valid, wait in DATA with grant held. There is no timeout.
- EOF:
  - When can_send: tx_start=1, tx_data=8'hAA.
  - Set rr_ptr = g+1, wrapping at N.
  - Clear grant and go to IDLE.
- A fragmented burst resumes in a new frame only when that port next wins arbitration.
- req_valid changes on non-granted ports never affect the current frame.
- len is 9 bits and is compared against MAX_LEN-1. It never wraps.
- Reset, from any state and including mid-byte:
  - Clears state to IDLE, rr_ptr=0, len=0, grant=0, tx_start=0, tx_data=8'h00, frag_pulse=0.
  - req_ready is 0 during reset.
  - A partially sent frame is abandoned with no EOF.

## Timing
- Arbitration takes one cycle: the IDLE cycle that sees req_valid registers grant, and SOF is evaluated the next cycle.
- Minimum request-to-SOF tx_start is 2 cycles when tx_busy is low.
- Byte spacing is at least 2 cycles: after a tx_start cycle, can_send is 0 for that next cycle.
- Further bytes then stall on tx_busy.
- req_ready and the tx_start/tx_data register load occur in the same edge. The requester's byte is consumed on the cycle req_ready is high.
- Frame overhead is 3 bytes.
- A 1-byte burst produces exactly 4 tx_start pulses: 0x55, ID, byte, 0xAA.
- frag_pulse coincides with the tx_start of the MAX_LEN-th payload byte.

## Test plan
- Single port: port 0 sends 3 bytes 0x10,0x11,0x12 (last on 0x12); UART model busy for 10 cycles per byte.
  - Expect tx_data sequence 55,00,10,11,12,AA.
  - Exactly 6 tx_start pulses, none while tx_busy=1; grant 01 then 00.
- Round-robin: N=2, both ports hold 1-byte bursts continuously, 4 frames.
  - Expect IDs 00,01,00,01.
  - grant never changes between SOF and EOF.
- Fragmentation: MAX_LEN=4, port 1 sends 6 bytes 0..5 with last on 5, port 0 idle.
  - Expect frame 55,01,00,01,02,03,AA with frag_pulse once.
  - Then frame 55,01,04,05,AA with no frag_pulse.
- Source stall: port 0 drops req_valid for 20 cycles mid-burst while port 1 requests.
  - Expect no EOF during the stall, grant held on port 0, and port 1 frame only after port 0's AA.
- Reset mid-frame: assert rst_n=0 during DATA.
  - Expect tx_start=0, tx_data=00, grant=0 immediately, asynchronously.
  - After release with port 1 requesting, the next frame starts 55,01, since rr_ptr was reset to 0 and port 0 is idle.
- Back-to-back timing: tx_busy tied low.
  - Expect tx_start exactly every 2 cycles across a full frame.
  - req_ready high only on the cycles the payload tx_start loads.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin framer that shares one byte-wide UART TX between N payload sources.
// Each granted burst goes out as 0x55, port ID, payload (at most MAX_LEN bytes), 0xAA.
module uart_tx_arbiter #(
    parameter int N       = 2,
    parameter int MAX_LEN = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     req_valid,
    input  logic [8*N-1:0]   req_data,
    input  logic [N-1:0]     req_last,
    output logic [N-1:0]     req_ready,
    input  logic             tx_busy,
    output logic             tx_start,
    output logic [7:0]       tx_data,
    output logic [N-1:0]     grant,
    output logic             frag_pulse,
    output logic [2:0]       state_dbg
);

    localparam int IDXW = (N > 1) ? $clog2(N) : 1;
    localparam logic [8:0] LEN_LAST = 9'(MAX_LEN - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_SOF  = 3'd1,
        S_ID   = 3'd2,
        S_DATA = 3'd3,
        S_EOF  = 3'd4
    } state_t;

    state_t          state;
    logic [IDXW-1:0] rr_ptr;
    logic [IDXW-1:0] gidx;
    logic [8:0]      len;

    logic            can_send;
    logic            found;
    logic [IDXW-1:0] pick;
    logic [N-1:0]    pick_onehot;
    logic [7:0]      sel_data;
    int              arb_j;

    assign state_dbg = state;

    // tx_start masks the single cycle before the UART raises tx_busy.
    assign can_send = !tx_busy && !tx_start;

    // Source handshake: a byte of port i moves on the rising edge where
    // req_valid[i] & req_ready[i]; the source holds data/last stable while valid
    // is high and not yet accepted. Only the owning port sees ready, in DATA.
    always_comb begin
        req_ready = '0;
        if (state == S_DATA) begin
            req_ready[gidx] = can_send && req_valid[gidx];
        end
    end

    assign sel_data = req_data[{gidx, 3'b000} +: 8];

    // First requester at or after rr_ptr, scanning upward with wrap.
    always_comb begin
        found       = 1'b0;
        pick        = '0;
        pick_onehot = '0;
        arb_j       = 0;
        for (int i = 0; i < N; i++) begin
            arb_j = int'(rr_ptr) + i;
            if (arb_j >= N) begin
                arb_j = arb_j - N;
            end
            if (!found && req_valid[arb_j]) begin
                found = 1'b1;
                pick  = arb_j[IDXW-1:0];
            end
        end
        pick_onehot[pick] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            rr_ptr     <= '0;
            gidx       <= '0;
            len        <= '0;
            grant      <= '0;
            tx_start   <= 1'b0;
            tx_data    <= 8'h00;
            frag_pulse <= 1'b0;
        end else begin
            tx_start   <= 1'b0;
            frag_pulse <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (found) begin
                        gidx  <= pick;
                        grant <= pick_onehot;
                        len   <= '0;
                        state <= S_SOF;
                    end
                end
                S_SOF: begin
                    if (can_send) begin
                        tx_start <= 1'b1;
                        tx_data  <= 8'h55;
                        state    <= S_ID;
                    end
                end
                S_ID: begin
                    if (can_send) begin
                        tx_start <= 1'b1;
                        tx_data  <= {{(8-IDXW){1'b0}}, gidx};
                        state    <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (can_send && req_valid[gidx]) begin
                        tx_start <= 1'b1;
                        tx_data  <= sel_data;
                        len      <= len + 9'd1;
                        if (req_last[gidx]) begin
                            state <= S_EOF;
                        end else if (len == LEN_LAST) begin
                            state      <= S_EOF;
                            frag_pulse <= 1'b1;
                        end
                    end
                end
                S_EOF: begin
                    if (can_send) begin
                        tx_start <= 1'b1;
                        tx_data  <= 8'hAA;
                        rr_ptr   <= (gidx == IDXW'(N - 1)) ? '0 : gidx + 1'b1;
                        grant    <= '0;
                        state    <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter (N=2, MAX_LEN=4): burst table plus
// hand-written round-robin, stall, mid-frame reset and back-to-back sequences.
module tb_uart_tx_arbiter;

    localparam int N       = 2;
    localparam int MAX_LEN = 4;

    logic           clk = 1'b0;
    logic           rst_n;
    logic [N-1:0]   req_valid;
    logic [8*N-1:0] req_data;
    logic [N-1:0]   req_last;
    logic [N-1:0]   req_ready;
    logic           tx_busy;
    logic           tx_start;
    logic [7:0]     tx_data;
    logic [N-1:0]   grant;
    logic           frag_pulse;
    logic [2:0]     state_dbg;

    uart_tx_arbiter #(.N(N), .MAX_LEN(MAX_LEN)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_data   (req_data),
        .req_last   (req_last),
        .req_ready  (req_ready),
        .tx_busy    (tx_busy),
        .tx_start   (tx_start),
        .tx_data    (tx_data),
        .grant      (grant),
        .frag_pulse (frag_pulse),
        .state_dbg  (state_dbg)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // ---------------- bookkeeping ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard entry: {frag_pulse, grant, tx_data}
    logic [10:0] exp_q[$];
    logic [8:0]  src_q0[$];
    logic [8:0]  src_q1[$];
    logic [1:0]  src_en = 2'b11;
    int          pop_cnt0 = 0;
    int          pop_cnt1 = 0;
    int          busy_len = 0;
    int          busy_cnt = 0;
    int          n_pulse = 0;
    int          n_frag = 0;
    logic        bb_rec = 1'b0;
    int          start_stamp[$];
    int          ready_stamp[$];

    // ---------------- driver: sources and UART busy model ----------------
    task automatic drive_sources();
        req_valid[0]   = src_en[0] && (src_q0.size() > 0);
        req_data[7:0]  = (src_q0.size() > 0) ? src_q0[0][7:0] : 8'h00;
        req_last[0]    = (src_q0.size() > 0) ? src_q0[0][8] : 1'b0;
        req_valid[1]   = src_en[1] && (src_q1.size() > 0);
        req_data[15:8] = (src_q1.size() > 0) ? src_q1[0][7:0] : 8'h00;
        req_last[1]    = (src_q1.size() > 0) ? src_q1[0][8] : 1'b0;
    endtask

    initial begin
        logic [N-1:0] fire;
        logic         ts;
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
        tx_busy   = 1'b0;
        forever begin
            @(negedge clk);
            fire = req_valid & req_ready;
            ts   = tx_start;
            @(posedge clk);
            #1;
            if (!rst_n) begin
                src_q0.delete();
                src_q1.delete();
                busy_cnt = 0;
            end else begin
                if (fire[0] && src_q0.size() > 0) begin
                    void'(src_q0.pop_front());
                    pop_cnt0++;
                end
                if (fire[1] && src_q1.size() > 0) begin
                    void'(src_q1.pop_front());
                    pop_cnt1++;
                end
                if (ts) busy_cnt = busy_len;
                else if (busy_cnt > 0) busy_cnt--;
            end
            tx_busy = (busy_cnt > 0);
            drive_sources();
        end
    end

    // Queue a burst on a port and push the frames it should produce.
    task automatic push_burst(input int port, input int nbytes, input logic [7:0] base);
        logic [1:0] oh;
        logic [7:0] d;
        logic [7:0] id;
        logic       last;
        logic       frag;
        int         c;
        oh = (port == 1) ? 2'b10 : 2'b01;
        id = 8'(port);
        c  = 0;
        for (int j = 0; j < nbytes; j++) begin
            d    = base + 8'(j);
            last = (j == nbytes - 1);
            if (c == 0) begin
                exp_q.push_back({1'b0, oh, 8'h55});
                exp_q.push_back({1'b0, oh, id});
            end
            frag = !last && (c == MAX_LEN - 1);
            exp_q.push_back({frag, oh, d});
            if (port == 1) src_q1.push_back({last, d});
            else           src_q0.push_back({last, d});
            c++;
            if (last || c == MAX_LEN) begin
                exp_q.push_back({1'b0, 2'b00, 8'hAA});
                c = 0;
            end
        end
    endtask

    // ---------------- monitor / scoreboard ----------------
    initial begin
        logic [10:0] e;
        logic [N-1:0] prev_grant;
        prev_grant = '0;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (tx_start) begin
                    n_pulse++;
                    if (frag_pulse) n_frag++;
                    check("start_while_busy", tx_busy, 0);
                    if (bb_rec) start_stamp.push_back(cyc);
                    if (exp_q.size() == 0) begin
                        n_checks++;
                        n_fail++;
                        $display("FAIL unexpected_tx_start: got %02h, expected no byte", tx_data);
                    end else begin
                        e = exp_q.pop_front();
                        check("tx_data", tx_data, e[7:0]);
                        check("grant_at_start", grant, e[9:8]);
                        check("frag_pulse", frag_pulse, e[10]);
                    end
                end else begin
                    check("frag_without_start", frag_pulse, 0);
                end
                if (bb_rec && req_ready != 0) ready_stamp.push_back(cyc);
                if (prev_grant != 0 && grant != 0) check("grant_stable", grant, prev_grant);
                prev_grant = grant;
            end else begin
                prev_grant = '0;
            end
        end
    end

    task automatic wait_done(input string name);
        logic ok;
        ok = 1'b0;
        for (int k = 0; k < 3000 && !ok; k++) begin
            @(negedge clk);
            #1;
            if (exp_q.size() == 0 && grant == 0 && state_dbg == 3'd0 &&
                src_q0.size() == 0 && src_q1.size() == 0) ok = 1'b1;
        end
        check(name, ok, 1);
    endtask

    task automatic wait_pop0(input int start, input string name);
        logic ok;
        ok = 1'b0;
        for (int k = 0; k < 500 && !ok; k++) begin
            @(posedge clk);
            #2;
            if (pop_cnt0 > start) ok = 1'b1;
        end
        check(name, ok, 1);
    endtask

    // ---------------- test table ----------------
    typedef struct {
        int         port;
        int         nbytes;
        int         busy;
        logic [7:0] base;
        int         exp_pulses;
        int         exp_frags;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int req_cyc;
        int p0;
        vecs[0] = '{port: 0, nbytes: 3, busy: 10, base: 8'h10, exp_pulses: 6,  exp_frags: 0};
        vecs[1] = '{port: 1, nbytes: 6, busy: 3,  base: 8'h00, exp_pulses: 12, exp_frags: 1};
        vecs[2] = '{port: 0, nbytes: 1, busy: 0,  base: 8'hA5, exp_pulses: 4,  exp_frags: 0};
        vecs[3] = '{port: 1, nbytes: 4, busy: 2,  base: 8'hC0, exp_pulses: 7,  exp_frags: 0};
        vecs[4] = '{port: 0, nbytes: 8, busy: 0,  base: 8'h80, exp_pulses: 14, exp_frags: 1};
        vecs[5] = '{port: 1, nbytes: 5, busy: 1,  base: 8'hE0, exp_pulses: 11, exp_frags: 1};

        // reset state
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_tx_start", tx_start, 0);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_grant", grant, 0);
        check("rst_req_ready", req_ready, 0);
        check("rst_frag", frag_pulse, 0);
        check("rst_state", state_dbg, 3'd0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // table-driven bursts
        foreach (vecs[i]) begin
            busy_len = vecs[i].busy;
            n_pulse  = 0;
            n_frag   = 0;
            push_burst(vecs[i].port, vecs[i].nbytes, vecs[i].base);
            wait_done($sformatf("vec%0d_done", i));
            check($sformatf("vec%0d_pulses", i), n_pulse, vecs[i].exp_pulses);
            check($sformatf("vec%0d_frags", i), n_frag, vecs[i].exp_frags);
        end

        // round-robin: both ports keep 1-byte bursts pending; IDs alternate 00,01,00,01
        busy_len = 2;
        n_pulse  = 0;
        push_burst(0, 1, 8'h60);
        push_burst(1, 1, 8'h70);
        push_burst(0, 1, 8'h61);
        push_burst(1, 1, 8'h71);
        wait_done("rr_done");
        check("rr_pulses", n_pulse, 16);

        // source stall: port 0 stops mid-burst while port 1 waits
        busy_len = 10;
        p0 = pop_cnt0;
        push_burst(0, 3, 8'h20);
        wait_pop0(p0, "stall_first_byte");
        src_en[0] = 1'b0;
        push_burst(1, 1, 8'h30);
        repeat (20) begin
            @(negedge clk);
            check("stall_grant", grant, 2'b01);
        end
        src_en[0] = 1'b1;
        wait_done("stall_done");

        // reset in the middle of a DATA phase
        p0 = pop_cnt0;
        push_burst(0, 3, 8'h40);
        wait_pop0(p0, "midrst_first_byte");
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_tx_start", tx_start, 0);
        check("midrst_tx_data", tx_data, 8'h00);
        check("midrst_grant", grant, 0);
        check("midrst_req_ready", req_ready, 0);
        check("midrst_state", state_dbg, 3'd0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        n_pulse = 0;
        push_burst(1, 1, 8'h41);
        wait_done("midrst_done");
        check("midrst_pulses", n_pulse, 4);

        // back-to-back with tx_busy low
        busy_len = 0;
        repeat (3) @(negedge clk);
        start_stamp.delete();
        ready_stamp.delete();
        bb_rec  = 1'b1;
        req_cyc = -100;
        push_burst(0, 3, 8'h50);
        for (int k = 0; k < 10 && req_cyc < 0; k++) begin
            @(negedge clk);
            if (req_valid[0]) req_cyc = cyc;
        end
        wait_done("bb_done");
        bb_rec = 1'b0;
        check("bb_start_count", start_stamp.size(), 6);
        check("bb_ready_count", ready_stamp.size(), 3);
        if (start_stamp.size() == 6) begin
            check("bb_req_to_sof", start_stamp[0] - req_cyc, 2);
            for (int k = 1; k < 6; k++) begin
                check($sformatf("bb_gap%0d", k), start_stamp[k] - start_stamp[k-1], 2);
            end
            if (ready_stamp.size() == 3) begin
                for (int k = 0; k < 3; k++) begin
                    check($sformatf("bb_ready%0d", k), ready_stamp[k], start_stamp[k+2] - 1);
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
